// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with HI/LO and a 32-step restoring divider.
// Define DIV_EN to build the divider; without it DIV/DIVU act as NOP and HI/LO stay 0.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] rdata1_i,
  input  logic [31:0] rdata2_i,
  input  logic [4:0]  waddr_reg_i,
  input  logic        we_reg_i,
  input  logic [31:0] return_addr_i,
  input  logic        now_in_delayslot_i,
  output logic        we_reg_o,
  output logic [4:0]  waddr_reg_o,
  output logic [31:0] wdata_o,
  output logic        now_in_delayslot_o,
  output logic        stallreq_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [7:0] EXE_MFHI_OP = 8'b00010000;
  localparam logic [7:0] EXE_MFLO_OP = 8'b00010010;
  localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
  localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;
  logic [31:0] logic_res, shift_res, sra_res, move_res;
  // kept apart so the arithmetic shift is not turned unsigned by a conditional
  assign sra_res = $signed(rdata2_i) >>> rdata1_i[4:0];
  always_comb begin
    logic_res = aluop_i == EXE_AND_OP ? rdata1_i & rdata2_i :
                aluop_i == EXE_OR_OP  ? rdata1_i | rdata2_i :
                aluop_i == EXE_XOR_OP ? rdata1_i ^ rdata2_i :
                aluop_i == EXE_NOR_OP ? ~(rdata1_i | rdata2_i) : '0;
    shift_res = aluop_i == EXE_SLL_OP ? rdata2_i << rdata1_i[4:0] :
                aluop_i == EXE_SRL_OP ? rdata2_i >> rdata1_i[4:0] :
                aluop_i == EXE_SRA_OP ? sra_res : '0;
    move_res = aluop_i == EXE_MFHI_OP ? hi_o : aluop_i == EXE_MFLO_OP ? lo_o : '0;
    wdata_o = rst                               ? '0 :
              alusel_i == EXE_RES_LOGIC         ? logic_res :
              alusel_i == EXE_RES_SHIFT         ? shift_res :
              alusel_i == EXE_RES_MOVE          ? move_res :
              alusel_i == EXE_RES_JUMP_BRANCH   ? return_addr_i : '0;
    we_reg_o = !rst && we_reg_i;
    waddr_reg_o = rst ? '0 : waddr_reg_i;
  end
  always_ff @(posedge clk) now_in_delayslot_o <= !rst && now_in_delayslot_i;
`ifdef DIV_EN
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [64:0] sr;
  logic [31:0] dvs, a_abs, b_abs;
  logic [32:0] top, diff;
  logic neg_q, neg_r, div_op, sgn, ge;
  assign div_op = aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP;
  assign sgn = aluop_i == EXE_DIV_OP;
  assign a_abs = sgn && rdata1_i[31] ? -rdata1_i : rdata1_i;
  assign b_abs = sgn && rdata2_i[31] ? -rdata2_i : rdata2_i;
  // partial remainder after the left shift of this step
  assign top = sr[63:31];
  assign ge = top >= {1'b0, dvs};
  assign diff = top - {1'b0, dvs};
  assign stallreq_o = !rst && div_op && state != DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end
    if (rst || flush_i) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (div_op) begin
          neg_q <= sgn && (rdata1_i[31] ^ rdata2_i[31]);
          neg_r <= sgn && rdata1_i[31];
          sr <= rdata2_i == '0 ? '0 : {33'b0, a_abs};
          dvs <= b_abs;
          cnt <= '0;
          state <= rdata2_i == '0 ? DONE : BUSY;
        end
        BUSY: begin
          sr <= ge ? {diff, sr[30:0], 1'b1} : {sr[63:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
        end
        DONE: begin
          lo_o <= neg_q ? -sr[31:0] : sr[31:0];
          hi_o <= neg_r ? -sr[63:32] : sr[63:32];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_div;
  assign unused_div = flush_i;
  assign stallreq_o = 1'b0;
  assign hi_o = '0;
  assign lo_o = '0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table, divide sequences and randomized checks against a reference model.
module tb_ex_stage;
  localparam logic [7:0] AND_OP = 8'b00100100, OR_OP = 8'b00100101, XOR_OP = 8'b00100110;
  localparam logic [7:0] NOR_OP = 8'b00100111, SLL_OP = 8'b01111100, SRL_OP = 8'b00000010;
  localparam logic [7:0] SRA_OP = 8'b00000011, MFHI_OP = 8'b00010000, MFLO_OP = 8'b00010010;
  localparam logic [7:0] DIV_OP = 8'b00011010, DIVU_OP = 8'b00011011;
  localparam logic [2:0] NOP = 3'b000, LOGIC = 3'b001, SHIFT = 3'b010, MOVE = 3'b011, JUMP = 3'b110;
`ifdef DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] op;
    logic [31:0] a, b, ra;
    logic w;
    logic [4:0] wa;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst, flush, we, ds, we_o, ds_o, stall;
  logic [7:0] op;
  logic [2:0] sel;
  logic [31:0] a, b, ra, wdata, hi, lo;
  logic [4:0] wa, wa_o;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  vec_t tbl [13];
  always #5 clk = ~clk;
  ex_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush), .aluop_i(op), .alusel_i(sel),
    .rdata1_i(a), .rdata2_i(b), .waddr_reg_i(wa), .we_reg_i(we), .return_addr_i(ra),
    .now_in_delayslot_i(ds), .we_reg_o(we_o), .waddr_reg_o(wa_o), .wdata_o(wdata),
    .now_in_delayslot_o(ds_o), .stallreq_o(stall), .hi_o(hi), .lo_o(lo)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] s, input logic [7:0] o,
                                        input logic [31:0] x, y, r);
    logic [31:0] p;
    p = 32'd1 << x[4:0];
    case (s)
      LOGIC: return o == AND_OP ? x & y : o == OR_OP ? x | y : o == XOR_OP ? x ^ y :
                    o == NOR_OP ? ~(x | y) : 32'd0;
      SHIFT: return o == SLL_OP ? y * p : o == SRL_OP ? y / p :
                    o == SRA_OP ? (y[31] ? ~(~y / p) : y / p) : 32'd0;
      MOVE:  return o == MFHI_OP ? exp_hi : o == MFLO_OP ? exp_lo : 32'd0;
      JUMP:  return r;
      default: return 32'd0;
    endcase
  endfunction
  task automatic div_model(input logic [7:0] o, input logic [31:0] x, y,
                           output logic [31:0] q, output logic [31:0] r);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (y == 0) begin q = 0; r = 0; end
    else if (o == DIVU_OP) begin q = x / y; r = x % y; end
    else begin q = 32'(sx / sy); r = 32'(sx % sy); end
  endtask
  task automatic do_div(input logic [7:0] o, input logic [31:0] x, y);
    logic [31:0] q, r;
    int n;
    @(negedge clk);
    flush = 0; op = o; sel = NOP; a = x; b = y; we = 0; wa = 0;
    n = 0;
    #1;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk($sformatf("div_stall_cycles %h/%h", x, y), n, DIV_ON ? (y != 0 ? 33 : 1) : 0);
    chk("div_hi_before_done_edge", hi, exp_hi);
    div_model(o, x, y, q, r);
    if (DIV_ON) begin exp_hi = r; exp_lo = q; end
    @(negedge clk);
    op = MFLO_OP; sel = MOVE; we = 1; wa = 5'd2;
    #1;
    chk("div_mflo", wdata, exp_lo);
    chk("div_lo", lo, exp_lo);
    chk("div_hi", hi, exp_hi);
    op = MFHI_OP;
    #1;
    chk("div_mfhi", wdata, exp_hi);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [2:0] sels [6];
    logic [7:0] ops [10];
    logic prev_ds;
    sels = '{LOGIC, SHIFT, MOVE, JUMP, NOP, 3'b111};
    ops = '{AND_OP, OR_OP, XOR_OP, NOR_OP, SLL_OP, SRL_OP, SRA_OP, MFHI_OP, MFLO_OP, 8'hFF};
    tbl[0]  = '{LOGIC, OR_OP,  32'h0000F0F0, 32'h00FF0000, 32'h0, 1'b1, 5'd3,  32'h00FFF0F0};
    tbl[1]  = '{SHIFT, SRA_OP, 32'h4,        32'hF0000000, 32'h0, 1'b1, 5'd4,  32'hFF000000};
    tbl[2]  = '{SHIFT, SRL_OP, 32'h4,        32'hF0000000, 32'h0, 1'b0, 5'd5,  32'h0F000000};
    tbl[3]  = '{SHIFT, SLL_OP, 32'h4,        32'hF000000F, 32'h0, 1'b1, 5'd6,  32'h000000F0};
    tbl[4]  = '{LOGIC, AND_OP, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 1'b1, 5'd7,  32'h0F0F0000};
    tbl[5]  = '{LOGIC, XOR_OP, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b1, 5'd8,  32'hF0F0F0F0};
    tbl[6]  = '{LOGIC, NOR_OP, 32'h0,        32'h0000FFFF, 32'h0, 1'b1, 5'd9,  32'hFFFF0000};
    tbl[7]  = '{JUMP,  8'h09,  32'h1,        32'h2,        32'h108, 1'b1, 5'd31, 32'h00000108};
    tbl[8]  = '{NOP,   OR_OP,  32'h1234,     32'h5678,     32'h44, 1'b0, 5'd1, 32'h0};
    tbl[9]  = '{3'b111, OR_OP, 32'h1234,     32'h5678,     32'h44, 1'b1, 5'd2, 32'h0};
    tbl[10] = '{MOVE,  MFHI_OP, 32'h1,       32'h2,        32'h0, 1'b1, 5'd10, 32'h0};
    tbl[11] = '{SHIFT, SRA_OP, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1, 5'd11, 32'hFFFFFFFF};
    tbl[12] = '{SHIFT, SRL_OP, 32'h00000020, 32'h12345678, 32'h0, 1'b1, 5'd12, 32'h12345678};
    rst = 1; flush = 0; op = OR_OP; sel = JUMP; a = 32'hF; b = 32'hF0; ra = 32'h44;
    we = 1; wa = 5'd9; ds = 1;
    @(negedge clk); #1;
    chk("rst_we", 32'(we_o), 0);
    chk("rst_waddr", 32'(wa_o), 0);
    chk("rst_wdata", wdata, 0);
    @(negedge clk); #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_delayslot", 32'(ds_o), 0);
    chk("rst_stall", 32'(stall), 0);
    rst = 0; ds = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      sel = tbl[i].sel; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; ra = tbl[i].ra;
      we = tbl[i].w; wa = tbl[i].wa;
      #1;
      chk($sformatf("vec%0d_wdata", i), wdata, tbl[i].exp);
      chk($sformatf("vec%0d_we", i), 32'(we_o), 32'(tbl[i].w));
      chk($sformatf("vec%0d_waddr", i), 32'(wa_o), 32'(tbl[i].wa));
    end
    @(negedge clk);
    sel = JUMP; ra = 32'h108; wa = 5'd31; we = 1; ds = 1;
    #1;
    chk("jalr_wdata", wdata, 32'h108);
    chk("ds_before", 32'(ds_o), 0);
    @(negedge clk); ds = 0; #1;
    chk("ds_after", 32'(ds_o), 1);
    @(negedge clk); #1;
    chk("ds_clear", 32'(ds_o), 0);
    do_div(DIV_OP, 32'hFFFFFFF9, 32'h2);
    do_div(DIVU_OP, 32'hFFFFFFFF, 32'h10);
    do_div(DIV_OP, 32'h12345678, 32'h0);
    do_div(DIV_OP, 32'h80000000, 32'hFFFFFFFF);
    do_div(DIV_OP, 32'h7, 32'hFFFFFFFE);
    for (int i = 0; i < 5; i++)
      do_div($urandom_range(0, 1) ? DIV_OP : DIVU_OP, $urandom, $urandom >> $urandom_range(0, 31));
    @(negedge clk);
    op = DIV_OP; sel = NOP; a = 32'd100; b = 32'd7; we = 0;
    repeat (10) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0; op = OR_OP; sel = NOP;
    #1;
    chk("flush_stall", 32'(stall), 0);
    repeat (40) @(negedge clk);
    #1;
    chk("flush_hi_kept", hi, exp_hi);
    chk("flush_lo_kept", lo, exp_lo);
    do_div(DIVU_OP, 32'd1000, 32'd7);
    @(negedge clk);
    op = DIV_OP; sel = NOP; a = 32'd1000; b = 32'd3; we = 0;
    repeat (5) @(negedge clk);
    rst = 1; op = OR_OP; sel = LOGIC; a = 32'hF; b = 32'hF0; we = 1; wa = 5'd4; ds = 1;
    #1;
    chk("rstmid_we", 32'(we_o), 0);
    chk("rstmid_waddr", 32'(wa_o), 0);
    chk("rstmid_wdata", wdata, 0);
    @(negedge clk); #1;
    chk("rstmid_hi", hi, 0);
    chk("rstmid_lo", lo, 0);
    chk("rstmid_ds", 32'(ds_o), 0);
    chk("rstmid_stall", 32'(stall), 0);
    rst = 0; ds = 0; exp_hi = 0; exp_lo = 0;
    do_div(DIV_OP, 32'h7, 32'hFFFFFFFE);
    @(negedge clk);
    prev_ds = ds;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      sel = sels[$urandom_range(0, 5)]; op = ops[$urandom_range(0, 9)];
      a = $urandom; b = $urandom; ra = $urandom; we = 1'($urandom); wa = 5'($urandom);
      ds = 1'($urandom);
      #1;
      chk($sformatf("rnd%0d_wdata sel=%0d op=%h", i, sel, op), wdata, model(sel, op, a, b, ra));
      chk($sformatf("rnd%0d_we", i), 32'(we_o), 32'(we));
      chk($sformatf("rnd%0d_waddr", i), 32'(wa_o), 32'(wa));
      chk($sformatf("rnd%0d_ds", i), 32'(ds_o), 32'(prev_ds));
      chk($sformatf("rnd%0d_stall", i), 32'(stall), 0);
      prev_ds = ds;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
